// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and status flags.
// Single-cycle ops complete on the accept edge; MUL iterates one shift-add step per cycle.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_neg
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic               r_neg;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [SW-1:0]      w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_accept  = in_valid && w_in_ready;
    assign w_is_mul  = MUL_EN && (alu_op == 4'b1010);
    assign w_sum     = {1'b0, input_a} + {1'b0, input_b};
    assign w_diff    = {1'b0, input_a} - {1'b0, input_b};
    assign w_shamt   = input_b[SW-1:0];
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    assign w_last    = (r_cnt == SW'(WIDTH - 1));

    // in_ready depends only on state, out_ready and reset, never on in_valid
    always_comb begin
        w_in_ready = 1'b0;
        if (rst) begin
            w_in_ready = 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  w_in_ready = 1'b1;
                S_DONE:  w_in_ready = out_ready;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    // Single-cycle result and flags; MUL and undefined opcodes fall to the zero default
    always_comb begin
        w_res   = {WIDTH{1'b0}};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (alu_op)
            4'b0000: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (input_a[WIDTH-1] == input_b[WIDTH-1]) && (w_sum[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'b0001: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (input_a[WIDTH-1] != input_b[WIDTH-1]) && (w_diff[WIDTH-1] != input_a[WIDTH-1]);
            end
            4'b0010: w_res = input_a & input_b;
            4'b0011: w_res = input_a | input_b;
            4'b0100: w_res = input_a ^ input_b;
            4'b0101: w_res = ~input_a;
            4'b0110: w_res = input_a << w_shamt;
            4'b0111: w_res = input_a >> w_shamt;
            4'b1000: w_res = {{(WIDTH-1){1'b0}}, (input_a == input_b)};
            4'b1001: w_res = {{(WIDTH-1){1'b0}}, ($signed(input_a) < $signed(input_b))};
            default: w_res = {WIDTH{1'b0}};
        endcase
    end

    // Next-state logic; a DONE-state accept behaves exactly like an IDLE accept
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
                end else if ((r_state == S_DONE) && !out_ready) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY:  w_state_nxt = w_last ? S_DONE : S_BUSY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Multiplier iteration and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= {SW{1'b0}};
            r_mcand     <= {(2*WIDTH){1'b0}};
            r_acc       <= {(2*WIDTH){1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept && w_is_mul) begin
                r_cnt    <= {SW{1'b0}};
                r_mcand  <= {{WIDTH{1'b0}}, input_a};
                r_acc    <= {(2*WIDTH){1'b0}};
                r_mplier <= input_b;
            end else if (r_state == S_BUSY) begin
                r_cnt    <= r_cnt + SW'(1);
                r_mcand  <= r_mcand << 1;
                r_acc    <= w_acc_nxt;
                r_mplier <= r_mplier >> 1;
            end
            if (w_accept && !w_is_mul) begin
                r_result <= w_res;
                r_zero   <= (w_res == {WIDTH{1'b0}});
                r_carry  <= w_carry;
                r_ovf    <= w_ovf;
                r_neg    <= w_res[WIDTH-1];
            end else if ((r_state == S_BUSY) && w_last) begin
                r_result <= w_acc_nxt[WIDTH-1:0];
                r_zero   <= (w_acc_nxt[WIDTH-1:0] == {WIDTH{1'b0}});
                r_carry  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_ovf    <= 1'b0;
                r_neg    <= w_acc_nxt[WIDTH-1];
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_ovf   = r_ovf;
    assign flag_neg   = r_neg;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8, MUL_EN=1): directed cases then randomized ops against an
// arithmetic reference model with random input/output stalls.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] input_a;
    logic [7:0] input_b;
    logic [3:0] alu_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_carry;
    logic       flag_ovf;
    logic       flag_neg;

    int n_pass   = 0;
    int n_checks = 0;

    alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf), .flag_neg(flag_neg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_zero, flag_carry, flag_ovf, flag_neg};
    endfunction

    // Reference model: {result[7:0], zero, carry, ovf, neg} from plain integer arithmetic
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r;
        bit c, v;
        logic [7:0] res;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        r = 0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            4'd1:  begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = 255 - ua;
            4'd6:  r = ua << (ub % 8);
            4'd7:  r = ua >> (ub % 8);
            4'd8:  r = (ua == ub) ? 1 : 0;
            4'd9:  r = (sa < sb) ? 1 : 0;
            4'd10: begin r = ua * ub; c = (r > 255); end
            default: r = 0;
        endcase
        res = r[7:0];
        return {res, (res == 8'd0), c, v, res[7]};
    endfunction

    // Issue one op from IDLE, measure edges from accept to out_valid, check result/flags
    task automatic dir_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] er, input logic [3:0] ef, input int elat);
        int cyc;
        bit rdy_bad;
        out_ready = 1'b1; in_valid = 1'b1; alu_op = op; input_a = a; input_b = b;
        #1;
        check({tag, "_in_ready"}, in_ready, 1'b1);
        step();
        in_valid = (elat > 0);
        input_a = 8'hA5; input_b = 8'h5A; alu_op = 4'b0000;
        cyc = 0; rdy_bad = 1'b0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, cyc, elat);
        check({tag, "_result"}, result, er);
        check({tag, "_flags"}, flags_now(), ef);
        if (elat > 0) check({tag, "_busy_in_ready"}, rdy_bad, 1'b0);
        step();
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] exp_v;
        int acc_n, cyc;
        bit stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        input_a = 8'h00; input_b = 8'h00; alu_op = 4'b0000;
        step(); step(); step();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, 8'h00);
        check("reset_flags", flags_now(), 4'b0000);
        check("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1'b1);

        dir_op("add_ff_01", 4'b0000, 8'hFF, 8'h01, 8'h00, 4'b1100, 0);
        dir_op("sub_80_01", 4'b0001, 8'h80, 8'h01, 8'h7F, 4'b0010, 0);
        dir_op("sub_01_02", 4'b0001, 8'h01, 8'h02, 8'hFF, 4'b0101, 0);
        dir_op("slt_80_7f", 4'b1001, 8'h80, 8'h7F, 8'h01, 4'b0000, 0);
        dir_op("sll_81_09", 4'b0110, 8'h81, 8'h09, 8'h02, 4'b0000, 0);
        dir_op("undef_op",  4'b1111, 8'h3C, 8'h77, 8'h00, 4'b1000, 0);
        dir_op("mul_0f_11", 4'b1010, 8'h0F, 8'h11, 8'hFF, 4'b0001, 8);
        dir_op("mul_20_10", 4'b1010, 8'h20, 8'h10, 8'h00, 4'b1100, 8);

        // Backpressure: result held while out_ready low, then drain+accept in one cycle
        out_ready = 1'b0; in_valid = 1'b1; alu_op = 4'b0000; input_a = 8'h10; input_b = 8'h20;
        step();
        input_a = 8'h05; input_b = 8'h06;
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_result_stable", result, 8'h30);
            check("bp_in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        step();
        check("bp_next_result", result, 8'h0B);
        check("bp_next_valid", out_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            input_a = 8'(i * 3); input_b = 8'(i + 7);
            step();
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_result", result, 8'(i * 4 + 7));
        end
        in_valid = 1'b0;
        step();
        check("b2b_drained", out_valid, 1'b0);

        // Reset in the third BUSY cycle of a MUL
        out_ready = 1'b1; in_valid = 1'b1; alu_op = 4'b1010; input_a = 8'h0F; input_b = 8'h11;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        check("midmul_rst_out_valid", out_valid, 1'b0);
        check("midmul_rst_result", result, 8'h00);
        check("midmul_rst_flags", flags_now(), 4'b0000);
        check("midmul_rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("midmul_idle_in_ready", in_ready, 1'b1);
        stale = 1'b0;
        repeat (12) begin
            if (out_valid) stale = 1'b1;
            step();
        end
        check("midmul_no_stale", stale, 1'b0);
        dir_op("add_02_03", 4'b0000, 8'h02, 8'h03, 8'h05, 4'b0000, 0);

        // Randomized ops with stalls against the reference model
        acc_n = 0; cyc = 0;
        while ((acc_n < 1000 || q.size() > 0) && cyc < 60000) begin
            in_valid  = (acc_n < 1000) && ($urandom_range(0, 9) < 7);
            input_a   = 8'($urandom);
            input_b   = 8'($urandom);
            alu_op    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_valid", out_valid, 1'b0);
                end else begin
                    exp_v = q.pop_front();
                    check("rand_result_flags", {result, flags_now()}, exp_v);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(alu_op, input_a, input_b));
                acc_n++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_all_completed", (acc_n == 1000) && (q.size() == 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
